amm_burst_responder: RTL and testbench

- Synthesizable Avalon-MM burst slave: the responder end of the memory checker's AMM master port.
- Backs a small internal word RAM. Accepts write bursts with byteenable and queues read commands in a request FIFO.
- Returns read bursts with fixed pipeline latency.
- Used as loopback target for checker bring-up and for self-test without external memory.

---
 rtl/amm_burst_responder.sv | 262 ++++++++++++++++++++++++++
 tb/tb_amm_burst_responder.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/amm_burst_responder.sv
// Avalon-MM burst slave backed by an internal word RAM; loopback target for the memory checker.
// Define AMM_RESP_ERR_INJECT_EN to add single-beat read-data error injection (err_inj_i/err_inj_byte_i).
module amm_burst_responder #(
    parameter int  AMM_ADDR_W    = 32,
    parameter int  AMM_DATA_W    = 512,
    parameter int  AMM_BURST_W   = 11,
    parameter int  MEM_WORDS_W   = 10,
    parameter int  RD_FIFO_DEPTH = 4,
    parameter int  RD_LATENCY    = 4,
    localparam int DATA_B_W      = AMM_DATA_W / 8,
    localparam int ADDR_B_W      = $clog2(DATA_B_W)
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic [AMM_ADDR_W-1:0]  amm_address_i,
    input  logic                   amm_read_i,
    input  logic                   amm_write_i,
    input  logic [AMM_DATA_W-1:0]  amm_writedata_i,
    input  logic [DATA_B_W-1:0]    amm_byteenable_i,
    input  logic [AMM_BURST_W-1:0] amm_burstcount_i,
    output logic                   amm_waitrequest_o,
    output logic [AMM_DATA_W-1:0]  amm_readdata_o,
`ifdef AMM_RESP_ERR_INJECT_EN
    input  logic                   err_inj_i,
    input  logic [ADDR_B_W-1:0]    err_inj_byte_i,
`endif
    output logic                   amm_readdatavalid_o
);

    localparam int MEM_DEPTH = 2 ** MEM_WORDS_W;
    localparam int PTR_W     = $clog2(RD_FIFO_DEPTH);
    localparam int CNT_W     = PTR_W + 1;

    localparam logic [MEM_WORDS_W-1:0] IDX_ONE  = MEM_WORDS_W'(1);
    localparam logic [AMM_BURST_W-1:0] BC_ONE   = AMM_BURST_W'(1);
    localparam logic [PTR_W-1:0]       PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0]       CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]       CNT_FULL = CNT_W'(RD_FIFO_DEPTH);

    typedef enum logic {WR_IDLE, WR_BURST} wr_state_t;
    typedef enum logic {RD_IDLE, RD_BURST} rd_state_t;

    typedef struct packed {
        logic [MEM_WORDS_W-1:0] index;
        logic [AMM_BURST_W-1:0] count;
    } rd_cmd_t;

    logic [AMM_DATA_W-1:0]  mem [MEM_DEPTH];

    logic [MEM_WORDS_W-1:0] cmd_index;
    logic                   addr_unused;
    logic                   wr_accept;
    logic                   rd_accept;

    wr_state_t              wr_state;
    logic [MEM_WORDS_W-1:0] wr_index;
    logic [AMM_BURST_W-1:0] wr_remaining;
    logic                   mem_wr_en;
    logic [MEM_WORDS_W-1:0] mem_wr_index;

    rd_cmd_t                fifo_mem [RD_FIFO_DEPTH];
    rd_cmd_t                fifo_head;
    logic [PTR_W-1:0]       fifo_wr_ptr;
    logic [PTR_W-1:0]       fifo_rd_ptr;
    logic [CNT_W-1:0]       fifo_count;
    logic [CNT_W-1:0]       fifo_count_next;
    logic                   fifo_push;
    logic                   fifo_pop;
    logic                   fifo_empty;

    rd_state_t              rd_state;
    logic [MEM_WORDS_W-1:0] rd_index;
    logic [AMM_BURST_W-1:0] rd_remaining;
    logic                   rd_issue;

    logic [RD_LATENCY-1:0]  pipe_valid;
    logic [AMM_DATA_W-1:0]  pipe_data [RD_LATENCY];

    // Only the word-index slice of the byte address matters; the rest is deliberately dropped.
    assign cmd_index   = amm_address_i[ADDR_B_W +: MEM_WORDS_W];
    assign addr_unused = ^amm_address_i;

    // Write wins when a master illegally raises read and write together.
    assign wr_accept = amm_write_i && !amm_waitrequest_o;
    assign rd_accept = amm_read_i && !amm_write_i && !amm_waitrequest_o;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned and infers a latch.
        mem_wr_en    = 1'b0;
        mem_wr_index = wr_index;
        if (wr_accept) begin
            if (wr_state == WR_IDLE) begin
                mem_wr_en    = (amm_burstcount_i != '0);
                mem_wr_index = cmd_index;
            end else begin
                mem_wr_en = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_state     <= WR_IDLE;
            wr_index     <= '0;
            wr_remaining <= '0;
        end else if (wr_accept) begin
            // NOTE: non-blocking assignments so every register in the design samples pre-edge values.
            case (wr_state)
                WR_IDLE: begin
                    if (amm_burstcount_i > BC_ONE) begin
                        wr_state     <= WR_BURST;
                        wr_index     <= cmd_index + IDX_ONE;
                        wr_remaining <= amm_burstcount_i - BC_ONE;
                    end
                end
                WR_BURST: begin
                    wr_index     <= wr_index + IDX_ONE;
                    wr_remaining <= wr_remaining - BC_ONE;
                    if (wr_remaining == BC_ONE) begin
                        wr_state <= WR_IDLE;
                    end
                end
                default: wr_state <= WR_IDLE;
            endcase
        end
    end

    // NOTE: storage arrays have no reset; RAM contents must survive rst_n_i and map onto block RAM.
    always_ff @(posedge clk_i) begin
        if (mem_wr_en) begin
            for (int b = 0; b < DATA_B_W; b++) begin
                if (amm_byteenable_i[b]) begin
                    mem[mem_wr_index][b*8 +: 8] <= amm_writedata_i[b*8 +: 8];
                end
            end
        end
    end

    // Zero-length reads are acknowledged but never enter the queue.
    assign fifo_push  = rd_accept && (amm_burstcount_i != '0);
    assign fifo_empty = (fifo_count == '0);
    assign fifo_head  = fifo_mem[fifo_rd_ptr];
    assign fifo_pop   = !fifo_empty && ((rd_state == RD_IDLE) || (rd_remaining == BC_ONE));

    always_comb begin
        fifo_count_next = fifo_count;
        case ({fifo_push, fifo_pop})
            2'b10:   fifo_count_next = fifo_count + CNT_ONE;
            2'b01:   fifo_count_next = fifo_count - CNT_ONE;
            default: fifo_count_next = fifo_count;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (fifo_push) begin
            fifo_mem[fifo_wr_ptr] <= '{index: cmd_index, count: amm_burstcount_i};
        end
    end

    // waitrequest is the registered full flag, so a same-cycle pop never frees a slot early.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            fifo_wr_ptr       <= '0;
            fifo_rd_ptr       <= '0;
            fifo_count        <= '0;
            amm_waitrequest_o <= 1'b1;
        end else begin
            if (fifo_push) begin
                fifo_wr_ptr <= fifo_wr_ptr + PTR_ONE;
            end
            if (fifo_pop) begin
                fifo_rd_ptr <= fifo_rd_ptr + PTR_ONE;
            end
            fifo_count        <= fifo_count_next;
            amm_waitrequest_o <= (fifo_count_next == CNT_FULL);
        end
    end

    // The last beat of a burst loads the next queued command, giving gapless back-to-back bursts.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rd_state     <= RD_IDLE;
            rd_index     <= '0;
            rd_remaining <= '0;
        end else begin
            case (rd_state)
                RD_IDLE: begin
                    if (fifo_pop) begin
                        rd_state     <= RD_BURST;
                        rd_index     <= fifo_head.index;
                        rd_remaining <= fifo_head.count;
                    end
                end
                RD_BURST: begin
                    if (rd_remaining == BC_ONE) begin
                        if (fifo_pop) begin
                            rd_index     <= fifo_head.index;
                            rd_remaining <= fifo_head.count;
                        end else begin
                            rd_state <= RD_IDLE;
                        end
                    end else begin
                        rd_index     <= rd_index + IDX_ONE;
                        rd_remaining <= rd_remaining - BC_ONE;
                    end
                end
                default: rd_state <= RD_IDLE;
            endcase
        end
    end

    assign rd_issue = (rd_state == RD_BURST);

    // Stage 0 is the RAM read register; a same-cycle write to that word is seen next time only.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pipe_valid <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                pipe_data[i] <= '0;
            end
        end else begin
            pipe_valid[0] <= rd_issue;
            if (rd_issue) begin
                pipe_data[0] <= mem[rd_index];
            end
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_data[i]  <= pipe_data[i-1];
            end
        end
    end

    assign amm_readdatavalid_o = pipe_valid[RD_LATENCY-1];

`ifdef AMM_RESP_ERR_INJECT_EN
    logic                  inj_armed;
    logic [ADDR_B_W-1:0]   inj_byte;
    logic [AMM_DATA_W-1:0] inj_mask;

    // One injection at a time: pulses arriving while armed are dropped.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            inj_armed <= 1'b0;
            inj_byte  <= '0;
        end else if (inj_armed) begin
            if (amm_readdatavalid_o) begin
                inj_armed <= 1'b0;
            end
        end else if (err_inj_i) begin
            inj_armed <= 1'b1;
            inj_byte  <= err_inj_byte_i;
        end
    end

    assign inj_mask       = AMM_DATA_W'(1) << {inj_byte, 3'b000};
    assign amm_readdata_o = pipe_data[RD_LATENCY-1]
                          ^ ((inj_armed && amm_readdatavalid_o) ? inj_mask : '0);
`else
    assign amm_readdata_o = pipe_data[RD_LATENCY-1];
`endif

endmodule

// File: tb/tb_amm_burst_responder.sv
// Scoreboard bench for amm_burst_responder: directed commands push expected beats,
// a negedge monitor pops and compares every readdatavalid beat.
module tb_amm_burst_responder;

    localparam int AMM_ADDR_W    = 32;
    localparam int AMM_DATA_W    = 512;
    localparam int AMM_BURST_W   = 11;
    localparam int RD_LATENCY    = 4;
    localparam int DATA_B_W      = AMM_DATA_W / 8;
    localparam int ADDR_B_W      = 6;

    logic                   clk_i = 1'b0;
    logic                   rst_n_i;
    logic [AMM_ADDR_W-1:0]  amm_address_i;
    logic                   amm_read_i;
    logic                   amm_write_i;
    logic [AMM_DATA_W-1:0]  amm_writedata_i;
    logic [DATA_B_W-1:0]    amm_byteenable_i;
    logic [AMM_BURST_W-1:0] amm_burstcount_i;
    logic                   amm_waitrequest_o;
    logic [AMM_DATA_W-1:0]  amm_readdata_o;
    logic                   amm_readdatavalid_o;
    logic                   err_inj_i;
    logic [ADDR_B_W-1:0]    err_inj_byte_i;

    logic [AMM_DATA_W-1:0]  exp_q [$];
    int                     vectors     = 0;
    int                     miscompares = 0;
    int                     cyc         = 0;
    int                     beat_cnt    = 0;
    int                     valid_cyc [256];

    amm_burst_responder dut (
        .clk_i               (clk_i),
        .rst_n_i             (rst_n_i),
        .amm_address_i       (amm_address_i),
        .amm_read_i          (amm_read_i),
        .amm_write_i         (amm_write_i),
        .amm_writedata_i     (amm_writedata_i),
        .amm_byteenable_i    (amm_byteenable_i),
        .amm_burstcount_i    (amm_burstcount_i),
        .amm_waitrequest_o   (amm_waitrequest_o),
        .amm_readdata_o      (amm_readdata_o),
`ifdef AMM_RESP_ERR_INJECT_EN
        .err_inj_i           (err_inj_i),
        .err_inj_byte_i      (err_inj_byte_i),
`endif
        .amm_readdatavalid_o (amm_readdatavalid_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input logic [AMM_DATA_W-1:0] act,
                         input logic [AMM_DATA_W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [AMM_DATA_W-1:0] fill(input logic [7:0] b);
        return {DATA_B_W{b}};
    endfunction

    function automatic logic [AMM_DATA_W-1:0] pat(input int i);
        logic [31:0] w;
        w = 32'hC0DE_0000 + 32'(i);
        return {(AMM_DATA_W/32){w}};
    endfunction

    // Monitor: every valid beat must match the oldest expected entry.
    always @(negedge clk_i) begin
        if (rst_n_i && amm_readdatavalid_o) begin
            if (beat_cnt < 256) valid_cyc[beat_cnt] = cyc;
            beat_cnt++;
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_beat: got %h expected no beat", amm_readdata_o);
            end else begin
                check("read_beat", amm_readdata_o, exp_q.pop_front());
            end
        end
    end

    task automatic wait_accept();
        int n = 0;
        while (amm_waitrequest_o && n < 200) begin
            @(posedge clk_i); #1;
            n++;
        end
        if (amm_waitrequest_o) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout: waitrequest still %b after %0d cycles, required 0", amm_waitrequest_o, n);
        end
        @(posedge clk_i); #1;
    endtask

    task automatic bus_write(input logic [AMM_ADDR_W-1:0] addr, input int bc,
                             input logic [AMM_DATA_W-1:0] data, input logic [DATA_B_W-1:0] be);
        amm_write_i      = 1'b1;
        amm_read_i       = 1'b0;
        amm_address_i    = addr;
        amm_burstcount_i = AMM_BURST_W'(bc);
        amm_writedata_i  = data;
        amm_byteenable_i = be;
        wait_accept();
    endtask

    task automatic bus_read(input logic [AMM_ADDR_W-1:0] addr, input int bc, output int acc_cyc);
        amm_write_i      = 1'b0;
        amm_read_i       = 1'b1;
        amm_address_i    = addr;
        amm_burstcount_i = AMM_BURST_W'(bc);
        wait_accept();
        acc_cyc = cyc;
    endtask

    task automatic bus_idle();
        amm_write_i = 1'b0;
        amm_read_i  = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge clk_i); #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_drain: %0d beats outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (8) begin
            @(posedge clk_i); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int first;
        logic [AMM_DATA_W-1:0] exp_word;

        rst_n_i          = 1'b0;
        amm_address_i    = '0;
        amm_read_i       = 1'b0;
        amm_write_i      = 1'b0;
        amm_writedata_i  = '0;
        amm_byteenable_i = '0;
        amm_burstcount_i = '0;
        err_inj_i        = 1'b0;
        err_inj_byte_i   = '0;

        // Reset state and release timing.
        repeat (3) @(negedge clk_i);
        check("rst_waitrequest", amm_waitrequest_o, 1);
        check("rst_readdatavalid", amm_readdatavalid_o, 0);
        check("rst_readdata", amm_readdata_o, 0);
        rst_n_i = 1'b1;
        #1;
        check("release_waitrequest_hold", amm_waitrequest_o, 1);
        @(posedge clk_i); #1;
        check("release_waitrequest_drop", amm_waitrequest_o, 0);
        check("release_readdatavalid", amm_readdatavalid_o, 0);

        // Burst of 4 at 0x40, readback latency.
        for (int k = 0; k < 4; k++) bus_write(32'h40, 4, fill(8'((k + 1) * 17)), '1);
        bus_idle();
        first = beat_cnt;
        for (int k = 0; k < 4; k++) exp_q.push_back(fill(8'((k + 1) * 17)));
        bus_read(32'h40, 4, acc);
        bus_idle();
        wait_drain("burst4");
        check("first_beat_latency", 512'(valid_cyc[first] - acc), 512'(RD_LATENCY + 1));

        // Partial byteenable over a full word.
        bus_write(32'h280, 1, fill(8'hAA), '1);
        bus_write(32'h280, 1, fill(8'h55), 64'h0F);
        bus_idle();
        exp_word = {{(DATA_B_W-4){8'hAA}}, {4{8'h55}}};
        exp_q.push_back(exp_word);
        bus_read(32'h280, 1, acc);
        bus_idle();
        wait_drain("byteenable");

        // Index wrap at the top word; upper address bits ignored.
        bus_write(32'h1234_FFC0, 2, fill(8'h77), '1);
        bus_write(32'h0000_0000, 2, fill(8'h88), '1);
        bus_idle();
        exp_q.push_back(fill(8'h88));
        bus_read(32'h0000_0000, 1, acc);
        exp_q.push_back(fill(8'h77));
        bus_read(32'h0000_FFC0, 1, acc);
        bus_idle();
        wait_drain("wrap");

        // Zero-length write changes nothing; zero-length read yields no beat.
        bus_write(32'h40, 0, fill(8'hFF), '1);
        bus_idle();
        bus_read(32'h40, 0, acc);
        exp_q.push_back(fill(8'h11));
        bus_read(32'h40, 1, acc);
        bus_idle();
        wait_drain("zero_len");

        // DEPTH+1 back-to-back bursts of 8: FIFO fills, beats gapless and in order.
        for (int i = 0; i < 40; i++) bus_write(32'h1900, 40, pat(i), '1);
        bus_idle();
        first = beat_cnt;
        for (int r = 0; r < 5; r++) begin
            for (int j = 0; j < 8; j++) exp_q.push_back(pat(r * 8 + j));
            bus_read(32'h1900 + 32'(r * 8 * 64), 8, acc);
        end
        check("fifo_full_waitrequest", amm_waitrequest_o, 1);
        bus_idle();
        wait_drain("fifo");
        check("gapless_bursts", 512'(valid_cyc[first + 39] - valid_cyc[first]), 512'(39));
        check("fifo_drained_waitrequest", amm_waitrequest_o, 0);

`ifdef AMM_RESP_ERR_INJECT_EN
        // Single-beat injection into byte 5.
        bus_write(32'h3200, 2, '0, '1);
        bus_write(32'h3200, 2, '0, '1);
        bus_idle();
        err_inj_byte_i = 6'd5;
        err_inj_i      = 1'b1;
        @(posedge clk_i); #1;
        err_inj_i      = 1'b0;
        exp_word = '0;
        exp_word[40] = 1'b1;
        exp_q.push_back(exp_word);
        exp_q.push_back('0);
        bus_read(32'h3200, 2, acc);
        bus_idle();
        wait_drain("err_inject");
`endif

        check("scoreboard_empty", 512'(exp_q.size()), 512'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
